chest_interp_seq: RTL

Sequential frequency-domain interpolator for the NB-IoT channel-estimation chain. It serially accepts NPIL pilot estimates of one real component (I or Q; instantiate twice for complex), spaced 3 subcarriers apart. It then streams the 3×-scaled linearly interpolated estimate for every subcarrier position, with optional linear extrapolation past the last pilot. Weighting is shift-add only; no multipliers or dividers. Downstream scaling by 1/3 is owned by the consumer.

---
 rtl/chest_interp_pkg.sv | 24 ++
 rtl/chest_wsum.sv | 42 ++++
 rtl/chest_interp_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/chest_interp_pkg.sv
// Shared types for the NB-IoT channel-estimate interpolator: FSM states,
// shift-add term encodings and the output width rule.
package chest_interp_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, INTERP, EXTRAP} state_e;

  typedef enum logic [2:0] {ZERO, X1, X2, X4, NEG1, NEG2} term_e;

  // Operand feeding one term slot: current/next pilot, last/penultimate pilot
  typedef enum logic [1:0] {SRC_EA, SRC_EB, SRC_L, SRC_P} src_e;

  typedef struct packed {
    src_e  src;
    term_e sel;
  } term_t;

  localparam int NTERM = 3;

  // Worst case 7*2^(IN_WIDTH-1) needs three extra bits
  function automatic int out_width(input int in_w);
    return in_w + 3;
  endfunction

endpackage

// File: rtl/chest_wsum.sv
// Combinational three-term shift-add weighting unit; each slot picks an
// operand and a x1/x2/x4/-x1/-x2 weight, sign-extended before summing.
module chest_wsum
  import chest_interp_pkg::*;
#(
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = out_width(IN_WIDTH)
) (
  input  term_t [NTERM-1:0]          terms,
  input  logic signed [IN_WIDTH-1:0] ea,
  input  logic signed [IN_WIDTH-1:0] eb,
  input  logic signed [IN_WIDTH-1:0] el,
  input  logic signed [IN_WIDTH-1:0] ep,
  output logic signed [OUT_WIDTH-1:0] sum
);

  always_comb begin
    logic signed [OUT_WIDTH-1:0] opx;
    logic signed [OUT_WIDTH-1:0] tv;
    sum = '0;
    for (int i = 0; i < NTERM; i++) begin
      opx = '0;
      tv  = '0;
      case (terms[i].src)
        SRC_EA:  opx = OUT_WIDTH'(ea);
        SRC_EB:  opx = OUT_WIDTH'(eb);
        SRC_L:   opx = OUT_WIDTH'(el);
        default: opx = OUT_WIDTH'(ep);
      endcase
      case (terms[i].sel)
        X1:      tv = opx;
        X2:      tv = opx <<< 1;
        X4:      tv = opx <<< 2;
        NEG1:    tv = -opx;
        NEG2:    tv = -(opx <<< 1);
        default: tv = '0;
      endcase
      sum = sum + tv;
    end
  end

endmodule

// File: rtl/chest_interp_seq.sv
// Serial pilot loader and 3x-scaled linear interpolator/extrapolator with a
// registered valid/ready output stage.
module chest_interp_seq
  import chest_interp_pkg::*;
#(
  parameter  int IN_WIDTH  = 17,
  parameter  int NPIL      = 4,
  localparam int OUT_WIDTH = out_width(IN_WIDTH),
  localparam int IDX_WIDTH = $clog2(3 * NPIL)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ext_en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]        out_idx,
  output logic                        out_last
);

  if (NPIL < 2) begin : g_npil_chk
    $error("chest_interp_seq: NPIL must be >= 2");
  end

  localparam int AW = (NPIL > 2) ? $clog2(NPIL) : 1;
  localparam logic [AW-1:0]        LASTA    = AW'(NPIL - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_INT = IDX_WIDTH'(3 * (NPIL - 1));
  localparam logic [IDX_WIDTH-1:0] LAST_EXT = IDX_WIDTH'(3 * NPIL - 1);

  state_e                          state;
  logic [AW-1:0]                   pcnt, a_cnt, eb_idx;
  logic [1:0]                      d_cnt;
  logic [IDX_WIDTH-1:0]            k, last_k;
  logic                            ext_q;
  logic [NPIL-1:0][IN_WIDTH-1:0]   pil;
  term_t [NTERM-1:0]               terms;
  logic signed [OUT_WIDTH-1:0]     wsum;
  logic                            adv, emit, finish;

  // Gated with reset so in_ready is low while reset is held
  assign in_ready = rst && (state == IDLE || state == LOAD);
  assign adv      = !out_valid || out_ready;
  assign last_k   = ext_q ? LAST_EXT : LAST_INT;
  assign eb_idx   = (a_cnt == LASTA) ? a_cnt : a_cnt + AW'(1);

  always_comb begin
    terms = '{default: '{src: SRC_EA, sel: ZERO}};
    if (a_cnt == LASTA && d_cnt != 2'd0) begin
      terms[0] = '{src: SRC_L, sel: X4};
      if (d_cnt == 2'd1) begin
        terms[1] = '{src: SRC_P, sel: NEG1};
      end else begin
        terms[1] = '{src: SRC_L, sel: X1};
        terms[2] = '{src: SRC_P, sel: NEG2};
      end
    end else begin
      case (d_cnt)
        2'd0: begin
          terms[0] = '{src: SRC_EA, sel: X2};
          terms[1] = '{src: SRC_EA, sel: X1};
        end
        2'd1: begin
          terms[0] = '{src: SRC_EA, sel: X2};
          terms[1] = '{src: SRC_EB, sel: X1};
        end
        default: begin
          terms[0] = '{src: SRC_EA, sel: X1};
          terms[1] = '{src: SRC_EB, sel: X2};
        end
      endcase
    end
  end

  chest_wsum #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_wsum (
    .terms (terms),
    .ea    ($signed(pil[a_cnt])),
    .eb    ($signed(pil[eb_idx])),
    .el    ($signed(pil[NPIL-1])),
    .ep    ($signed(pil[NPIL-2])),
    .sum   (wsum)
  );

  // Sample 0 only needs E_0, so it is emitted on the last pilot's handshake
  always_comb begin
    emit   = 1'b0;
    finish = 1'b0;
    if (state == LOAD && in_valid && pcnt == LASTA) begin
      emit = 1'b1;
    end else if ((state == INTERP || state == EXTRAP) && adv) begin
      if (out_valid && out_last) finish = 1'b1;
      else                       emit   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      a_cnt     <= '0;
      d_cnt     <= '0;
      k         <= '0;
      ext_q     <= 1'b0;
      pil       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          pil[0] <= in_data;
          pcnt   <= AW'(1);
          ext_q  <= ext_en;
          state  <= LOAD;
        end
        LOAD: if (in_valid) begin
          pil[pcnt] <= in_data;
          if (pcnt == LASTA) begin
            pcnt  <= '0;
            state <= INTERP;
          end else begin
            pcnt <= pcnt + AW'(1);
          end
        end
        INTERP: if (emit && k == LAST_INT && ext_q) state <= EXTRAP;
        EXTRAP: ;
        default: state <= IDLE;
      endcase

      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= wsum;
        out_idx   <= k;
        out_last  <= (k == last_k);
        k         <= k + IDX_WIDTH'(1);
        if (d_cnt == 2'd2) begin
          d_cnt <= 2'd0;
          if (a_cnt != LASTA) a_cnt <= a_cnt + AW'(1);
        end else begin
          d_cnt <= d_cnt + 2'd1;
        end
      end

      if (finish) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        k         <= '0;
        a_cnt     <= '0;
        d_cnt     <= '0;
        state     <= IDLE;
      end
    end
  end

endmodule
